bht_spec: RTL and testbench
===========================

BHT_SPEC -- requirements
Module: bht_spec

Interface
REQ-001 SHALL provide parameter IDX_W, default 10, table index width; depth is 2^IDX_W entries.
REQ-002 SHALL provide parameter HIST_W, default 10, local history bits per entry.
REQ-003 SHALL provide parameter CKPT_DEPTH, default 8, checkpoint FIFO entries; power of two, at least 2.
REQ-004 SHALL provide: clock  in  1  sole clock, rising edge; all state is in this domain.
REQ-005 SHALL provide: reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-006 SHALL provide: rd_idx_i  in  IDX_W  read index from the speculative fetch PC.
REQ-007 SHALL provide: rd_hist_o  out  HIST_W  history for the PHT index, combinational from rd_idx_i.
REQ-008 SHALL provide: spec_vld_i  in  1 / spec_idx_i  in  IDX_W / spec_dir_i  in  1  speculative predicted-direction shift-in.
REQ-009 SHALL provide: spec_rdy_o  out  1  speculative update accepted when spec_vld_i and spec_rdy_o are both high.
REQ-010 SHALL provide: cm_vld_i  in  1 / cm_idx_i  in  IDX_W / cm_dir_i  in  1  committed branch, in program order.
REQ-011 SHALL provide: busy_o  out  1  high in states INIT and REPAIR.
REQ-012 SHALL provide: ckpt_cnt_o  out  $clog2(CKPT_DEPTH)+1  checkpoint FIFO occupancy.

Function
REQ-013 SHALL implement FSM states INIT, RUN and REPAIR; reset enters INIT.
REQ-014 INIT SHALL clear one entry per cycle from index 0 up to 2^IDX_W-1, then enter RUN; INIT lasts exactly 2^IDX_W cycles.
REQ-015 rd_hist_o SHALL be 0 in INIT and SHALL read the table in RUN and REPAIR.
REQ-016 spec_rdy_o SHALL be high only in RUN with the FIFO not full.
REQ-017 On an accepted speculative update, the FIFO SHALL push {spec_idx_i, old entry, spec_dir_i}, and the table SHALL write {old[HIST_W-2:0], spec_dir_i} on the next edge.
REQ-018 If rd_idx_i equals spec_idx_i during an accepted update, rd_hist_o SHALL bypass the shifted value in the same cycle.
REQ-019 A commit in RUN with cm_dir_i equal to the head's recorded direction SHALL pop the head with no table write.
REQ-020 A commit in RUN with a mismatched direction SHALL enter REPAIR, and any same-cycle speculative update SHALL be discarded.
REQ-021 REPAIR SHALL restore one FIFO entry per cycle, youngest to oldest, writing the recorded old entry; it takes N cycles for occupancy N.
REQ-022 The final REPAIR cycle (the head entry) SHALL write {head_old[HIST_W-2:0], cm_dir_i captured at the mispredict}, empty the FIFO and return to RUN.
REQ-023 A same-cycle accepted speculative update and matching commit SHALL push and pop together, leaving occupancy unchanged.
REQ-024 A commit while the FIFO is empty, or while in INIT or REPAIR, SHALL be ignored, and a simulation assertion SHALL fire.
REQ-025 Repeated speculative updates to the same index SHALL each record the then-current entry, so that youngest-first restore is exact.

Reset
REQ-026 Reset SHALL set the state to INIT, the INIT counter to 0 and the FIFO pointers and count to 0.
REQ-027 After reset, outputs SHALL be busy_o=1, spec_rdy_o=0, ckpt_cnt_o=0 and rd_hist_o=0.
REQ-028 Reset asserted during REPAIR or INIT SHALL abort the operation and restart INIT from index 0.

Configuration
REQ-029 Macro BHT_SPEC_REPAIR_EN SHALL enable speculative update, the checkpoint FIFO and the REPAIR state.
REQ-030 Without BHT_SPEC_REPAIR_EN: spec_rdy_o=0 and ckpt_cnt_o=0; each commit writes {entry[HIST_W-2:0], cm_dir_i} at cm_idx_i; rd_idx_i==cm_idx_i bypasses the shifted value; the FSM is INIT/RUN only.

Structure
REQ-031 Package bht_pkg SHALL hold the FSM state enum and the checkpoint entry struct {idx, old_hist, dir}, parameterised via localparams.
REQ-032 The checkpoint FIFO SHALL be sub-module bht_ckpt_fifo, supporting push, pop-head and pop-tail (restore walk).

Verification (IDX_W=4, HIST_W=4, CKPT_DEPTH=4)
REQ-033 Release reset -> busy_o high for exactly 16 cycles, then every rd_idx_i returns 0000.
REQ-034 Spec idx 3 with dirs 1,1,1 -> rd_hist_o(3) reads 0111; the third push with rd_idx_i=3 bypasses 0111 in the same cycle.
REQ-035 Entry 3 holds 0101; spec dirs 1,1; commit cm_dir_i=0 -> REPAIR for 2 cycles, entry 3 = 1010, ckpt_cnt_o=0.
REQ-036 Four spec pushes -> spec_rdy_o=0 and the fifth is not accepted; one matching commit -> spec_rdy_o=1 and ckpt_cnt_o=3.
REQ-037 Reset asserted on the 2nd REPAIR cycle -> INIT for 16 cycles, all entries 0, ckpt_cnt_o=0.
REQ-038 Macro off: commit idx 5 with dirs 1,0 -> entry 5 = 0010, with bypass on a same-cycle read of idx 5.

Source files
------------

// File: rtl/bht_pkg.sv
// bht_pkg: shared types for the bht_spec local branch-history table.
// Checkpoint fields use fixed maximum widths so any IDX_W/HIST_W up to them fit.
package bht_pkg;

    localparam int CKPT_IDX_MAX  = 16;
    localparam int CKPT_HIST_MAX = 32;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPAIR = 2'd2
    } state_e;

    typedef struct packed {
        logic [CKPT_IDX_MAX-1:0]  idx;
        logic [CKPT_HIST_MAX-1:0] old_hist;
        logic                     dir;
    } ckpt_t;

endpackage

// File: rtl/bht_spec_if.sv
// bht_spec_if: fetch-read, speculative-update and commit bundle of bht_spec.
// Parameters must match those of the attached bht_spec instance.
interface bht_spec_if #(
    parameter int IDX_W      = 10,
    parameter int HIST_W     = 10,
    parameter int CKPT_DEPTH = 8
);
    logic [IDX_W-1:0]            rd_idx_i;
    logic [HIST_W-1:0]           rd_hist_o;
    logic                        spec_vld_i;
    logic [IDX_W-1:0]            spec_idx_i;
    logic                        spec_dir_i;
    logic                        spec_rdy_o;
    logic                        cm_vld_i;
    logic [IDX_W-1:0]            cm_idx_i;
    logic                        cm_dir_i;
    logic                        busy_o;
    logic [$clog2(CKPT_DEPTH):0] ckpt_cnt_o;

    modport master (
        output rd_idx_i, spec_vld_i, spec_idx_i, spec_dir_i,
        output cm_vld_i, cm_idx_i, cm_dir_i,
        input  rd_hist_o, spec_rdy_o, busy_o, ckpt_cnt_o
    );

    modport slave (
        input  rd_idx_i, spec_vld_i, spec_idx_i, spec_dir_i,
        input  cm_vld_i, cm_idx_i, cm_dir_i,
        output rd_hist_o, spec_rdy_o, busy_o, ckpt_cnt_o
    );
endinterface

// File: rtl/bht_ckpt_fifo.sv
// bht_ckpt_fifo: checkpoint ring for speculative history updates.
// Head pops retire on commit; tail pops walk back youngest-first on repair.
module bht_ckpt_fifo
    import bht_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  ckpt_t         push_d,
    input  logic          pop_head,
    input  logic          pop_tail,
    output ckpt_t         head,
    output ckpt_t         tail,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);
    ckpt_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign tail  = mem[wr_ptr - PW'(1)];
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            else if (pop_tail)
                wr_ptr <= wr_ptr - PW'(1);
            if (pop_head)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop_head) - CW'(pop_tail);
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= push_d;
    end
endmodule

// File: rtl/bht_spec.sv
// bht_spec: per-entry local branch history, cleared by a walk after reset.
// Define BHT_SPEC_REPAIR_EN for speculative shift-in, checkpoints and REPAIR.
module bht_spec
    import bht_pkg::*;
#(
    parameter int IDX_W      = 10,
    parameter int HIST_W     = 10,
    parameter int CKPT_DEPTH = 8
) (
    input logic       clock,
    input logic       reset,
    bht_spec_if.slave bus
);
    localparam int CW = $clog2(CKPT_DEPTH) + 1;

    state_e            state;
    logic [IDX_W-1:0]  init_cnt;
    logic [HIST_W-1:0] tbl [2**IDX_W];
    logic              run;
    logic              upd;
    logic [IDX_W-1:0]  upd_idx;
    logic [HIST_W-1:0] upd_val;
    logic              to_repair;
    logic              repair_done;
    logic [IDX_W-1:0]  rep_idx;
    logic [HIST_W-1:0] rep_val;
    logic              we;
    logic [IDX_W-1:0]  wa;
    logic [HIST_W-1:0] wd;
    ckpt_t             push_d;
    ckpt_t             head;
    ckpt_t             tail;
    logic              push;
    logic              pop_head;
    logic              pop_tail;
    logic              full;
    logic              empty;
    logic [CW-1:0]     cnt;

    assign run = state == ST_RUN;

    bht_ckpt_fifo #(.DEPTH(CKPT_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .push_d  (push_d),
        .pop_head(pop_head),
        .pop_tail(pop_tail),
        .head    (head),
        .tail    (tail),
        .cnt     (cnt),
        .full    (full),
        .empty   (empty)
    );

`ifdef BHT_SPEC_REPAIR_EN
    logic              cm_ok;
    logic              mispredict;
    logic              rep_dir;
    logic [HIST_W-1:0] spec_old;
    logic              unused_ok;

    assign spec_old       = tbl[bus.spec_idx_i];
    assign cm_ok          = run && bus.cm_vld_i && !empty;
    assign mispredict     = cm_ok && (bus.cm_dir_i != head.dir);
    assign pop_head       = cm_ok && !mispredict;
    assign bus.spec_rdy_o = run && !full;
    // A mispredict squashes the younger path, this cycle's update included.
    assign push     = bus.spec_vld_i && bus.spec_rdy_o && !mispredict;
    assign pop_tail = state == ST_REPAIR;
    assign push_d   = '{idx:      CKPT_IDX_MAX'(bus.spec_idx_i),
                        old_hist: CKPT_HIST_MAX'(spec_old),
                        dir:      bus.spec_dir_i};

    assign upd         = push;
    assign upd_idx     = bus.spec_idx_i;
    assign upd_val     = {spec_old[HIST_W-2:0], bus.spec_dir_i};
    assign to_repair   = mispredict;
    assign repair_done = cnt == CW'(1);
    assign rep_idx     = tail.idx[IDX_W-1:0];
    // The last entry is the mispredicted branch: rebuild it with the real outcome.
    assign rep_val = repair_done
                   ? {tail.old_hist[HIST_W-2:0], rep_dir}
                   : tail.old_hist[HIST_W-1:0];
    assign bus.ckpt_cnt_o = cnt;
    assign unused_ok      = ^{head, tail, bus.cm_idx_i};

    always_ff @(posedge clock) begin
        if (mispredict)
            rep_dir <= bus.cm_dir_i;
    end

    always_ff @(posedge clock) begin
        if (!reset && bus.cm_vld_i)
            assert (run && !empty)
            else $error("bht_spec: commit outside RUN or with no checkpoint");
    end
`else
    logic [HIST_W-1:0] cm_old;
    logic              unused_spec;

    assign cm_old         = tbl[bus.cm_idx_i];
    assign push           = 1'b0;
    assign pop_head       = 1'b0;
    assign pop_tail       = 1'b0;
    assign push_d         = '0;
    assign upd            = run && bus.cm_vld_i;
    assign upd_idx        = bus.cm_idx_i;
    assign upd_val        = {cm_old[HIST_W-2:0], bus.cm_dir_i};
    assign to_repair      = 1'b0;
    assign repair_done    = 1'b0;
    assign rep_idx        = '0;
    assign rep_val        = '0;
    assign bus.spec_rdy_o = 1'b0;
    assign bus.ckpt_cnt_o = '0;
    assign unused_spec    = ^{bus.spec_vld_i, bus.spec_idx_i,
                              bus.spec_dir_i, head, tail,
                              full, empty, cnt};

    always_ff @(posedge clock) begin
        if (!reset && bus.cm_vld_i)
            assert (state != ST_INIT)
            else $error("bht_spec: commit during table clear");
    end
`endif

    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        unique case (state)
            ST_INIT: begin
                we = 1'b1;
                wa = init_cnt;
            end
            ST_RUN: begin
                we = upd;
                wa = upd_idx;
                wd = upd_val;
            end
            ST_REPAIR: begin
                we = 1'b1;
                wa = rep_idx;
                wd = rep_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (we && !reset)
            tbl[wa] <= wd;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + IDX_W'(1);
                    if (&init_cnt)
                        state <= ST_RUN;
                end
                ST_RUN:    if (to_repair) state <= ST_REPAIR;
                ST_REPAIR: if (repair_done) state <= ST_RUN;
                default:   state <= ST_INIT;
            endcase
        end
    end

    assign bus.busy_o    = !run;
    assign bus.rd_hist_o = (state == ST_INIT) ? '0
                         : (upd && bus.rd_idx_i == upd_idx) ? upd_val
                         : tbl[bus.rd_idx_i];
endmodule

// File: tb/tb_bht_spec.sv
// tb_bht_spec: randomized scoreboard bench for bht_spec (IDX_W=HIST_W=CKPT_DEPTH=4).
// Expected outputs come from a queue/array model of the table's rules.
module tb_bht_spec;
    localparam int IW = 4;
    localparam int HW = 4;
    localparam int DP = 4;

    logic clock;
    logic reset;

    bht_spec_if #(.IDX_W(IW), .HIST_W(HW), .CKPT_DEPTH(DP)) bus ();

    bht_spec #(.IDX_W(IW), .HIST_W(HW), .CKPT_DEPTH(DP)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [HW-1:0] hist;
        logic          rdy;
        logic          busy;
        logic [2:0]    cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [HW-1:0] mtab [16];
    int            init_left;
    bit            repairing;
    bit            known;
    int            checks;
    int            errors;
`ifdef BHT_SPEC_REPAIR_EN
    typedef struct {
        int            idx;
        logic [HW-1:0] old;
        bit            dir;
    } ck_t;
    ck_t ck[$];
    bit  rep_dir;
`endif

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, req);
        end
    endtask

    // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_hist", 8'(bus.rd_hist_o), 8'(e.hist));
            chk("spec_rdy", 8'(bus.spec_rdy_o), 8'(e.rdy));
            chk("busy", 8'(bus.busy_o), 8'(e.busy));
            chk("ckpt_cnt", 8'(bus.ckpt_cnt_o), 8'(e.cnt));
        end
    end

    task automatic cyc(input bit rst, input int rd,
                       input bit sv, input int si, input bit sd,
                       input bit cv, input int ci, input bit cd);
        exp_t e;
`ifdef BHT_SPEC_REPAIR_EN
        bit  acc;
        bit  mis;
        ck_t c;
        acc = 1'b0;
        mis = 1'b0;
`endif
        @(posedge clock);
        #1;
        reset          = rst;
        bus.rd_idx_i   = IW'(rd);
        bus.spec_vld_i = sv;
        bus.spec_idx_i = IW'(si);
        bus.spec_dir_i = sd;
        bus.cm_vld_i   = cv;
        bus.cm_idx_i   = IW'(ci);
        bus.cm_dir_i   = cd;
        if (known) begin
            e.busy = (init_left > 0) || repairing;
            e.rdy  = 1'b0;
            e.cnt  = '0;
            e.hist = mtab[rd];
            if (init_left > 0) begin
                e.hist = '0;
            end else if (!repairing) begin
`ifdef BHT_SPEC_REPAIR_EN
                e.rdy = ck.size() < DP;
                mis = cv && ck.size() > 0 && cd != ck[0].dir;
                acc = sv && e.rdy && !mis;
                if (acc && rd == si)
                    e.hist = {mtab[si][HW-2:0], sd};
`else
                if (cv && rd == ci)
                    e.hist = {mtab[ci][HW-2:0], cd};
`endif
            end
`ifdef BHT_SPEC_REPAIR_EN
            e.cnt = 3'(ck.size());
`endif
            exp_q.push_back(e);
        end
        if (rst) begin
            known     = 1'b1;
            init_left = 1 << IW;
            repairing = 1'b0;
`ifdef BHT_SPEC_REPAIR_EN
            ck.delete();
`endif
        end else if (!known) begin
            init_left = 0;
        end else if (init_left > 0) begin
            init_left--;
            if (init_left == 0)
                foreach (mtab[i]) mtab[i] = '0;
        end else if (repairing) begin
`ifdef BHT_SPEC_REPAIR_EN
            c = ck.pop_back();
            if (ck.size() == 0) begin
                mtab[c.idx] = {c.old[HW-2:0], rep_dir};
                repairing   = 1'b0;
            end else begin
                mtab[c.idx] = c.old;
            end
`endif
        end else begin
`ifdef BHT_SPEC_REPAIR_EN
            if (mis) begin
                repairing = 1'b1;
                rep_dir   = cd;
            end else begin
                if (cv)
                    c = ck.pop_front();
                if (acc) begin
                    ck.push_back('{si, mtab[si], sd});
                    mtab[si] = {mtab[si][HW-2:0], sd};
                end
            end
`else
            if (cv)
                mtab[ci] = {mtab[ci][HW-2:0], cd};
`endif
        end
    endtask

    task automatic idle(input int rd);
        cyc(1'b0, rd, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        while (init_left > 0)
            idle(int'($urandom_range(0, 15)));
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        known          = 1'b0;
        init_left      = 0;
        repairing      = 1'b0;
        reset          = 1'b1;
        bus.rd_idx_i   = '0;
        bus.spec_vld_i = 1'b0;
        bus.spec_idx_i = '0;
        bus.spec_dir_i = 1'b0;
        bus.cm_vld_i   = 1'b0;
        bus.cm_idx_i   = '0;
        bus.cm_dir_i   = 1'b0;

        do_reset();
        for (int i = 0; i < 16; i++) idle(i);

`ifdef BHT_SPEC_REPAIR_EN
        for (int k = 0; k < 3; k++) cyc(0, 3, 1, 3, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 3, 0, 0, 0, 1, 3, 1);
        idle(3);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(0, 3, 1, 3, bit'(k % 2), 0, 0, 0);
            cyc(0, 3, 0, 0, 0, 1, 3, bit'(k % 2));
        end
        cyc(0, 3, 1, 3, 1, 0, 0, 0);
        cyc(0, 3, 1, 3, 1, 0, 0, 0);
        cyc(0, 3, 0, 0, 0, 1, 3, 0);
        repeat (3) idle(3);
        for (int k = 0; k < 5; k++) cyc(0, 7, 1, 7, 1, 0, 0, 0);
        cyc(0, 7, 0, 0, 0, 1, 7, 1);
        idle(7);
        cyc(0, 7, 0, 0, 0, 1, 7, 0);
        idle(7);
        do_reset();
        for (int i = 0; i < 16; i++) idle(i);
`else
        cyc(0, 5, 0, 0, 0, 1, 5, 1);
        cyc(0, 5, 0, 0, 0, 1, 5, 0);
        idle(5);
        cyc(0, 4, 1, 4, 1, 1, 5, 1);
        idle(5);
        do_reset();
        idle(5);
`endif

        for (int n = 0; n < 3000; n++) begin
            bit rst, sv, sd, cv, cd, run_ok;
            int rd, si, ci, pick;
            run_ok = (init_left == 0) && !repairing;
            rst = repairing ? ($urandom_range(0, 5) == 0)
                            : ($urandom_range(0, 499) == 0);
            si  = $urandom_range(0, 1) ? 3 : int'($urandom_range(0, 15));
            ci  = $urandom_range(0, 1) ? 5 : int'($urandom_range(0, 15));
            sv  = !rst && ($urandom_range(0, 1) == 1);
            sd  = bit'($urandom_range(0, 1));
            cd  = bit'($urandom_range(0, 1));
`ifdef BHT_SPEC_REPAIR_EN
            cv = !rst && run_ok && ck.size() > 0 &&
                 ($urandom_range(0, 2) == 0);
            if (cv && $urandom_range(0, 4) != 0)
                cd = ck[0].dir;
`else
            cv = !rst && run_ok && ($urandom_range(0, 1) == 1);
`endif
            pick = $urandom_range(0, 3);
            rd = (pick == 0) ? si : (pick == 1) ? ci
               : int'($urandom_range(0, 15));
            cyc(rst, rd, sv, si, sd, cv, ci, cd);
        end

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
